// File: rtl/lockstep_miter_cmp.sv
// Lockstep comparator for dual-instance miter harnesses: delays copy A by LAG cycles,
// compares it against copy B under a bit mask, and tracks the first failure and mismatch count.
module lockstep_miter_cmp #(
  parameter int NCH        = 4,
  parameter int W          = 128,
  parameter int LAG        = 2,
  parameter int ARM_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear,
  input  logic [NCH*W-1:0]         ch_a,
  input  logic [NCH*W-1:0]         ch_b,
  input  logic [NCH*W-1:0]         ch_mask,
  output logic [NCH-1:0]           mismatch_ch_o,
  output logic                     mismatch_o,
  output logic                     fail_o,
  output logic [$clog2(NCH)-1:0]   first_ch_o,
  output logic [CNT_W-1:0]         first_cyc_o,
  output logic [CNT_W-1:0]         mis_cnt_o,
  output logic [1:0]               state_o
);

  localparam int FW = $clog2(NCH);
  localparam int AW = $clog2(LAG + ARM_CYCLES + 1);
  localparam logic [AW-1:0] ARM_LOAD = AW'(LAG + ARM_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    CHECK = 2'd2,
    FAIL  = 2'd3
  } state_t;

  state_t            state_r;
  logic [AW-1:0]     arm_cnt_r;
  logic [CNT_W-1:0]  chk_cnt_r;
  logic              tail_v_s;
  logic [NCH*W-1:0]  tail_d_s;
  logic [NCH-1:0]    cmp_s;
  logic              in_chk_s;

  function automatic logic [FW-1:0] lowest_idx(input logic [NCH-1:0] v);
    lowest_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest_idx = FW'(i);
      end
    end
  endfunction

  generate
    if (LAG == 0) begin : g_direct
      assign tail_v_s = en;
      assign tail_d_s = ch_a;
    end else begin : g_delay
      logic [LAG-1:0]   v_r;
      logic [NCH*W-1:0] d_r [LAG];

      // Copy-A delay line; valid bits are flushed whenever checking is disabled or cleared.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_r <= '0;
          for (int i = 0; i < LAG; i++) begin
            d_r[i] <= '0;
          end
        end else begin
          if (clear || !en) begin
            v_r <= '0;
          end else begin
            v_r[0] <= 1'b1;
            for (int i = 1; i < LAG; i++) begin
              v_r[i] <= v_r[i-1];
            end
          end
          d_r[0] <= ch_a;
          for (int i = 1; i < LAG; i++) begin
            d_r[i] <= d_r[i-1];
          end
        end
      end

      assign tail_v_s = v_r[LAG-1];
      assign tail_d_s = d_r[LAG-1];
    end
  endgenerate

  // Per-channel masked compare; a zero mask bit forces that bit's difference to zero.
  always_comb begin
    cmp_s = '0;
    for (int i = 0; i < NCH; i++) begin
      cmp_s[i] = tail_v_s & (|((tail_d_s[i*W +: W] ^ ch_b[i*W +: W]) & ch_mask[i*W +: W]));
    end
  end

  assign in_chk_s = (state_r == CHECK) || (state_r == FAIL);
  assign state_o  = state_r;

  // Control FSM with mismatch flags, saturating counters and first-failure capture.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_r       <= IDLE;
      arm_cnt_r     <= '0;
      chk_cnt_r     <= '0;
      mismatch_ch_o <= '0;
      mismatch_o    <= 1'b0;
      fail_o        <= 1'b0;
      first_ch_o    <= '0;
      first_cyc_o   <= '0;
      mis_cnt_o     <= '0;
    end else begin
      mismatch_ch_o <= in_chk_s ? cmp_s : '0;
      mismatch_o    <= in_chk_s & (|cmp_s);
      if (in_chk_s && (|cmp_s) && (mis_cnt_o != {CNT_W{1'b1}})) begin
        mis_cnt_o <= mis_cnt_o + CNT_W'(1);
      end
      if (!en) begin
        // A latched failure survives en dropping; everything else restarts.
        if (state_r != FAIL) begin
          state_r   <= IDLE;
          arm_cnt_r <= '0;
          chk_cnt_r <= '0;
        end
      end else begin
        case (state_r)
          IDLE: begin
            state_r   <= ARM;
            arm_cnt_r <= ARM_LOAD;
          end
          ARM: begin
            if (arm_cnt_r <= AW'(1)) begin
              state_r   <= CHECK;
              arm_cnt_r <= '0;
              chk_cnt_r <= '0;
            end else begin
              arm_cnt_r <= arm_cnt_r - AW'(1);
            end
          end
          CHECK: begin
            if (chk_cnt_r != {CNT_W{1'b1}}) begin
              chk_cnt_r <= chk_cnt_r + CNT_W'(1);
            end
            if (|cmp_s) begin
              state_r     <= FAIL;
              fail_o      <= 1'b1;
              first_ch_o  <= lowest_idx(cmp_s);
              first_cyc_o <= chk_cnt_r;
            end
          end
          FAIL: begin
            fail_o <= 1'b1;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lockstep_miter_cmp.sv
// Bench for lockstep_miter_cmp: directed vector table and corner sequences plus randomized
// traffic, all checked against a history-based reference model of the comparator.
module tb_lockstep_miter_cmp;

  logic         clk = 1'b0;
  logic         rst, en, clear;
  logic [511:0] ch_a, ch_b, ch_mask;
  logic [63:0]  a4, b4, m4;

  logic [3:0]  mch0, mch4;
  logic        mis0, mis4, fail0, fail4;
  logic [1:0]  fch0, fch4, st0, st4;
  logic [15:0] fcyc0, cnt0;
  logic [3:0]  fcyc4, cnt4;

  always #5 clk = ~clk;

  lockstep_miter_cmp #(.NCH(4), .W(128), .LAG(2), .ARM_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .ch_a(ch_a), .ch_b(ch_b), .ch_mask(ch_mask),
    .mismatch_ch_o(mch0), .mismatch_o(mis0), .fail_o(fail0), .first_ch_o(fch0),
    .first_cyc_o(fcyc0), .mis_cnt_o(cnt0), .state_o(st0));

  lockstep_miter_cmp #(.NCH(4), .W(16), .LAG(0), .ARM_CYCLES(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .ch_a(a4), .ch_b(b4), .ch_mask(m4),
    .mismatch_ch_o(mch4), .mismatch_o(mis4), .fail_o(fail4), .first_ch_o(fch4),
    .first_cyc_o(fcyc4), .mis_cnt_o(cnt4), .state_o(st4));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: index 0 = dut, index 1 = dut4
  int lag_p  [2] = '{2, 0};
  int arm_p  [2] = '{5, 2};
  int w_p    [2] = '{128, 16};
  int cmax_p [2] = '{65535, 15};
  int ph [2], age [2], chkc [2], mcnt [2], mfch [2], mfcyc [2];
  logic [3:0]   mmch [2];
  logic [511:0] hd [2][16];
  logic         hv [2][16];

  logic [511:0] p1, p2, corr, mask;
  logic [63:0]  corr4, mask4;

  typedef struct {
    logic [3:0] chs;
    int         bitn;
    int         cyc;
    logic       mlo;
    logic [3:0] exp_mch;
    logic       exp_fail;
    int         exp_fch;
    int         exp_cnt;
  } vec_t;

  vec_t tv [5];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input logic e, input logic c, input logic r,
                            input logic [511:0] a, input logic [511:0] b, input logic [511:0] m);
    logic         tvld;
    logic [511:0] td, diff;
    logic [3:0]   cmp;
    bit           any;
    if (lag_p[k] == 0) begin
      tvld = e;
      td   = a;
    end else begin
      tvld = hv[k][lag_p[k]-1];
      td   = hd[k][lag_p[k]-1];
    end
    diff = (td ^ b) & m;
    for (int i = 0; i < 4; i++) begin
      any = 1'b0;
      for (int j = 0; j < w_p[k]; j++) begin
        if (diff[i*w_p[k] + j]) any = 1'b1;
      end
      cmp[i] = tvld & any;
    end
    if (r || c) begin
      ph[k] = 0; age[k] = 0; chkc[k] = 0; mcnt[k] = 0; mfch[k] = 0; mfcyc[k] = 0;
      mmch[k] = 4'b0000;
    end else begin
      mmch[k] = (ph[k] >= 2) ? cmp : 4'b0000;
      if (ph[k] >= 2 && cmp != 4'b0000 && mcnt[k] < cmax_p[k]) mcnt[k]++;
      if (!e) begin
        if (ph[k] != 3) begin
          ph[k] = 0; age[k] = 0; chkc[k] = 0;
        end
      end else begin
        case (ph[k])
          0: begin ph[k] = 1; age[k] = 0; end
          1: begin
            age[k]++;
            if (age[k] >= arm_p[k]) begin ph[k] = 2; chkc[k] = 0; end
          end
          2: begin
            if (cmp != 4'b0000) begin
              ph[k] = 3;
              for (int i = 3; i >= 0; i--) if (cmp[i]) mfch[k] = i;
              mfcyc[k] = (chkc[k] > cmax_p[k]) ? cmax_p[k] : chkc[k];
            end else begin
              chkc[k]++;
            end
          end
          default: ;
        endcase
      end
    end
    // history of applied copy-A values; any disable or clear invalidates all of it
    for (int j = 15; j > 0; j--) begin
      hd[k][j] = hd[k][j-1];
      hv[k][j] = (e && !c && !r) ? hv[k][j-1] : 1'b0;
    end
    hd[k][0] = a;
    hv[k][0] = e && !c && !r;
  endtask

  task automatic compare_all();
    chk("st",    st0,   ph[0]);    chk("st4",    st4,   ph[1]);
    chk("mch",   mch0,  mmch[0]);  chk("mch4",   mch4,  mmch[1]);
    chk("mis",   mis0,  (mmch[0] != 4'b0000)); chk("mis4", mis4, (mmch[1] != 4'b0000));
    chk("fail",  fail0, (ph[0] == 3)); chk("fail4", fail4, (ph[1] == 3));
    chk("fch",   fch0,  mfch[0]);  chk("fch4",   fch4,  mfch[1]);
    chk("fcyc",  fcyc0, mfcyc[0]); chk("fcyc4",  fcyc4, mfcyc[1]);
    chk("cnt",   cnt0,  mcnt[0]);  chk("cnt4",   cnt4,  mcnt[1]);
  endtask

  task automatic step();
    logic [511:0] a;
    for (int i = 0; i < 16; i++) a[i*32 +: 32] = $urandom;
    ch_a = a; ch_b = p2 ^ corr; ch_mask = mask;
    a4 = a[63:0]; b4 = a[63:0] ^ corr4; m4 = mask4;
    @(posedge clk);
    model_step(0, en, clear, rst, a, p2 ^ corr, mask);
    model_step(1, en, clear, rst, {448'd0, a[63:0]}, {448'd0, a[63:0] ^ corr4}, {448'd0, mask4});
    p2 = p1;
    p1 = a;
    #1;
    compare_all();
  endtask

  initial begin
    int arm0, arm4, seen;
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; age[k] = 0; chkc[k] = 0; mcnt[k] = 0; mfch[k] = 0; mfcyc[k] = 0; mmch[k] = 4'b0000;
      for (int j = 0; j < 16; j++) begin hd[k][j] = '0; hv[k][j] = 1'b0; end
    end
    p1 = '0; p2 = '0; corr = '0; corr4 = 64'd0;
    mask = {512{1'b1}}; mask4 = {64{1'b1}};
    rst = 1'b1; en = 1'b0; clear = 1'b0;

    tv[0] = '{4'b0100,   3, 10, 1'b0, 4'b0100, 1'b1, 2, 1};
    tv[1] = '{4'b1010,  17,  3, 1'b0, 4'b1010, 1'b1, 1, 1};
    tv[2] = '{4'b0001,   5,  2, 1'b1, 4'b0000, 1'b0, 0, 0};
    tv[3] = '{4'b0001,   8,  2, 1'b1, 4'b0001, 1'b1, 0, 1};
    tv[4] = '{4'b1000, 127,  0, 1'b0, 4'b1000, 1'b1, 3, 1};

    // reset state
    step(); step();
    chk("rst_state", st0, 0); chk("rst_fail", fail0, 0); chk("rst_cnt", cnt0, 0);
    chk("rst_mch", mch0, 0);

    // clean lockstep run
    rst = 1'b0; en = 1'b1;
    arm0 = 0; arm4 = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (st0 == 2'd1) arm0++;
      if (st4 == 2'd1) arm4++;
      if (mis0 || mis4) seen++;
    end
    chk("arm_len", arm0, 5); chk("arm_len4", arm4, 2);
    chk("clean_state", st0, 2); chk("clean_mis", seen, 0); chk("clean_cnt", cnt0, 0);

    // single-shot corruption vectors
    for (int r = 0; r < 5; r++) begin
      mask = {512{1'b1}};
      if (tv[r].mlo) mask[7:0] = 8'h00;
      clear = 1'b1; step(); clear = 1'b0;
      chk("clr_state", st0, 0);
      for (int i = 0; i < 6 + tv[r].cyc; i++) step();
      corr = '0;
      for (int c = 0; c < 4; c++) if (tv[r].chs[c]) corr[c*128 + tv[r].bitn] = 1'b1;
      step();
      corr = '0;
      chk("vec_mch",  mch0,  tv[r].exp_mch);
      chk("vec_mis",  mis0,  (tv[r].exp_mch != 4'b0000));
      chk("vec_fail", fail0, tv[r].exp_fail);
      chk("vec_st",   st0,   tv[r].exp_fail ? 3 : 2);
      chk("vec_fch",  fch0,  tv[r].exp_fch);
      chk("vec_fcyc", fcyc0, tv[r].exp_fail ? tv[r].cyc : 0);
      chk("vec_cnt",  cnt0,  tv[r].exp_cnt);
      step();
      chk("vec_mch_after",  mch0,  0);
      chk("vec_fail_after", fail0, tv[r].exp_fail);
    end
    mask = {512{1'b1}};

    // saturation of a narrow mismatch counter, then clear against a live mismatch
    clear = 1'b1; step(); clear = 1'b0;
    corr4 = 64'h1;
    for (int i = 0; i < 25; i++) step();
    chk("sat_cnt4", cnt4, 15); chk("sat_fail4", fail4, 1); chk("sat_fch4", fch4, 0);
    chk("sat_fcyc4", fcyc4, 0);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_st4", st4, 0); chk("clr_cnt4", cnt4, 0); chk("clr_mch4", mch4, 0);
    chk("clr_fail4", fail4, 0);
    corr4 = 64'd0;

    // en drop during CHECK, re-arm, then reset while failed
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 9; i++) step();
    en = 1'b0; step(); en = 1'b1;
    chk("endrop_state", st0, 0);
    arm0 = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (st0 == 2'd1) arm0++;
    end
    chk("rearm_len", arm0, 5); chk("rearm_state", st0, 2);
    corr = '0; corr[0] = 1'b1; step(); corr = '0;
    chk("pre_rst_fail", fail0, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_fail2", fail0, 0); chk("rst_state2", st0, 0); chk("rst_cnt2", cnt0, 0);
    chk("rst_fcyc2", fcyc0, 0); chk("rst_mch2", mch0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int b;
      en    = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 49) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      corr  = '0;
      corr4 = 64'd0;
      if ($urandom_range(0, 9) == 0) begin b = $urandom_range(0, 511); corr[b] = 1'b1; end
      if ($urandom_range(0, 9) == 0) begin b = $urandom_range(0, 63); corr4[b] = 1'b1; end
      if ($urandom_range(0, 1) == 0) begin
        mask = {512{1'b1}}; mask4 = {64{1'b1}};
      end else begin
        for (int j = 0; j < 16; j++) mask[j*32 +: 32] = $urandom;
        mask4 = {$urandom, $urandom};
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
